fetch_stage: RTL and testbench

- Instruction-fetch front end, directly upstream of the branch predictor and decode.
- Owns the fetch PC, issues one-outstanding requests to instruction memory, and buffers returned instructions in a small FIFO presented to ID with a valid/ready handshake.
- Accepts a redirect (predicted-taken target or mispredict recovery from the predictor/flush path).
- On redirect it discards buffered and in-flight instructions using an epoch bit.

---
 rtl/fetch_stage_if.sv | 48 ++++
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: imem request/response and ID handshake
// bundle between the fetch stage and its neighbours.
interface fetch_stage_if #(
  parameter int DEPTH = 2
);
  logic                    imem_req;
  logic [31:0]             imem_addr;
  logic                    imem_gnt;
  logic                    imem_rvalid;
  logic [31:0]             imem_rdata;
  logic                    redirect;
  logic [31:0]             redirect_pc;
  logic                    id_valid;
  logic                    id_ready;
  logic [31:0]             id_inst;
  logic [31:0]             id_pc;
  logic [$clog2(DEPTH):0]  fifo_count;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    input  redirect,
    input  redirect_pc,
    output id_valid,
    input  id_ready,
    output id_inst,
    output id_pc,
    output fifo_count
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    output redirect,
    output redirect_pc,
    input  id_valid,
    output id_ready,
    input  id_inst,
    input  id_pc,
    input  fifo_count
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: one-outstanding instruction fetch with
// epoch-tagged flush and a small FIFO toward decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t        state;
  logic [31:0]   pc_q;
  logic [31:0]   req_pc;
  logic          epoch;
  logic          req_epoch;

  logic [31:0]   fifo_inst [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          has_room;
  logic          not_empty;
  logic          issue;
  logic          push;
  logic          pop;

  // Request, push and pop decode from registered state.
  always_comb begin
    has_room  = count < CW'(DEPTH);
    not_empty = count != '0;
    bus.imem_req = rst
                 && state == IDLE
                 && has_room
                 && !bus.redirect;
    bus.imem_addr = pc_q;
    issue = bus.imem_req && bus.imem_gnt;
    push  = rst
          && state == WAIT
          && bus.imem_rvalid
          && req_epoch == epoch
          && !bus.redirect;
    pop   = rst
          && not_empty
          && bus.id_ready
          && !bus.redirect;
    bus.id_valid   = not_empty;
    bus.id_inst    = not_empty ? fifo_inst[rd_ptr] : '0;
    bus.id_pc      = not_empty ? fifo_pc[rd_ptr] : '0;
    bus.fifo_count = count;
  end

  // Fetch FSM: PC, epoch and in-flight request tag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      pc_q      <= RESET_PC;
      epoch     <= 1'b0;
      req_pc    <= '0;
      req_epoch <= 1'b0;
    end else if (bus.redirect) begin
      pc_q  <= {bus.redirect_pc[31:2], 2'b00};
      epoch <= ~epoch;
      if (state == WAIT && bus.imem_rvalid)
        state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (issue) begin
            req_pc    <= pc_q;
            req_epoch <= epoch;
            pc_q      <= pc_q + 32'd4;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO pointers and occupancy; redirect empties it.
  always_ff @(posedge clk) begin
    if (!rst || bus.redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= bus.imem_rdata;
      fifo_pc[wr_ptr]   <= req_pc;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: vector table plus scoreboard of
// granted fetches checked against what reaches decode.
module tb_fetch_stage;
  logic clk;
  logic rst;

  fetch_stage_if #(.DEPTH(2)) bus ();

  fetch_stage #(
    .RESET_PC(32'h0000_0100),
    .DEPTH   (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    logic        g;
    logic        rv;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic [1:0]  cnt;
    logic [31:0] pc;
  } vec_t;

  exp_t        sbq[$];
  logic [31:0] glog[$];
  int          gcyc[$];
  logic [31:0] plog[$];
  logic [31:0] out_addr;
  logic        pend;
  int          cyc_n;
  int          n_cmp;
  int          n_bad;
  vec_t        tbl[16];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic g,
                       input logic rv, input logic rdy,
                       input logic rd, input logic [31:0] rpc);
    exp_t e;
    @(negedge clk);
    rst             = r;
    bus.imem_gnt    = g;
    bus.imem_rvalid = rv;
    bus.id_ready    = rdy;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.imem_rdata  = mem_f(out_addr);
    #1;
    cyc_n++;
    if (!r || rd) begin
      sbq.delete();
    end else begin
      if (bus.id_valid && rdy) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_empty: got pop of pc %h want none",
                   bus.id_pc);
        end else begin
          e = sbq.pop_front();
          chk("sb_pc", bus.id_pc, e.pc);
          chk("sb_inst", bus.id_inst, e.inst);
          plog.push_back(bus.id_pc);
        end
      end
      if (bus.imem_req && g) begin
        e.pc   = bus.imem_addr;
        e.inst = mem_f(bus.imem_addr);
        sbq.push_back(e);
        out_addr = bus.imem_addr;
        glog.push_back(bus.imem_addr);
        gcyc.push_back(cyc_n);
      end
    end
    pend = r && bus.imem_req && g;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    pend = 1'b0;
  endtask

  task automatic auto_run(input int n, input logic rdy);
    for (int i = 0; i < n; i++)
      drive(1'b1, 1'b1, pend, rdy, 1'b0, 32'h0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc_n = 0;
    pend  = 1'b0;
    out_addr = 32'h0;
    rst = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.id_ready    = 1'b0;

    tbl[0]  = '{1, 0, 0, 1, 32'h100, 0, 32'h0};
    tbl[1]  = '{1, 1, 0, 0, 32'h104, 0, 32'h0};
    tbl[2]  = '{1, 0, 0, 1, 32'h104, 1, 32'h100};
    tbl[3]  = '{1, 1, 0, 0, 32'h108, 1, 32'h100};
    tbl[4]  = '{1, 0, 0, 0, 32'h108, 2, 32'h100};
    tbl[5]  = '{1, 0, 1, 0, 32'h108, 2, 32'h100};
    tbl[6]  = '{1, 0, 0, 1, 32'h108, 1, 32'h104};
    tbl[7]  = '{1, 1, 1, 0, 32'h10c, 1, 32'h104};
    tbl[8]  = '{0, 0, 0, 1, 32'h10c, 1, 32'h108};
    tbl[9]  = '{0, 0, 0, 1, 32'h10c, 1, 32'h108};
    tbl[10] = '{0, 0, 0, 1, 32'h10c, 1, 32'h108};
    tbl[11] = '{1, 0, 0, 1, 32'h10c, 1, 32'h108};
    tbl[12] = '{0, 0, 1, 0, 32'h110, 1, 32'h108};
    tbl[13] = '{0, 1, 1, 0, 32'h110, 0, 32'h0};
    tbl[14] = '{0, 0, 1, 1, 32'h110, 1, 32'h10c};
    tbl[15] = '{0, 0, 0, 1, 32'h110, 0, 32'h0};

    // reset values
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("rst_req", 32'(bus.imem_req), 32'h0);
    chk("rst_valid", 32'(bus.id_valid), 32'h0);
    chk("rst_inst", bus.id_inst, 32'h0);
    chk("rst_pc", bus.id_pc, 32'h0);
    chk("rst_count", 32'(bus.fifo_count), 32'h0);

    // backpressure, wait states and gnt stall
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, tbl[i].g, tbl[i].rv, tbl[i].rdy,
            1'b0, 32'h0);
      chk($sformatf("v%0d_req", i),
          32'(bus.imem_req), 32'(tbl[i].req));
      chk($sformatf("v%0d_addr", i),
          bus.imem_addr, tbl[i].addr);
      chk($sformatf("v%0d_cnt", i),
          32'(bus.fifo_count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_valid", i),
          32'(bus.id_valid), 32'(tbl[i].cnt != 0));
      chk($sformatf("v%0d_pc", i), bus.id_pc, tbl[i].pc);
      chk($sformatf("v%0d_inst", i), bus.id_inst,
          tbl[i].cnt != 0 ? mem_f(tbl[i].pc) : 32'h0);
    end

    // streaming: one request every 2 cycles
    do_reset();
    glog.delete();
    gcyc.delete();
    auto_run(10, 1'b1);
    if (glog.size() < 3) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stream_grants: got %0d want >=3",
               glog.size());
    end else begin
      chk("stream_a0", glog[0], 32'h100);
      chk("stream_a1", glog[1], 32'h104);
      chk("stream_a2", glog[2], 32'h108);
      chk("stream_gap1", 32'(gcyc[1] - gcyc[0]), 32'd2);
      chk("stream_gap2", 32'(gcyc[2] - gcyc[1]), 32'd2);
    end

    // redirect in WAIT with one entry buffered
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2003);
    chk("rdw_cnt_pre", 32'(bus.fifo_count), 32'd1);
    chk("rdw_req", 32'(bus.imem_req), 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rdw_cnt", 32'(bus.fifo_count), 32'd0);
    chk("rdw_valid", 32'(bus.id_valid), 32'd0);
    chk("rdw_wait_req", 32'(bus.imem_req), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("rdw_drop_cnt", 32'(bus.fifo_count), 32'd0);
    chk("rdw_req2", 32'(bus.imem_req), 32'd1);
    chk("rdw_addr", bus.imem_addr, 32'h2000);
    plog.delete();
    pend = 1'b0;
    auto_run(6, 1'b1);
    chk("rdw_first_pc",
        plog.size() > 0 ? plog[0] : 32'hffff_ffff, 32'h2000);

    // redirect with rvalid, then a second redirect
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h5000);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h3000);
    chk("rr_req_forced", 32'(bus.imem_req), 32'd0);
    chk("rr_cnt_mid", 32'(bus.fifo_count), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("rr_cnt", 32'(bus.fifo_count), 32'd0);
    chk("rr_req", 32'(bus.imem_req), 32'd1);
    chk("rr_addr", bus.imem_addr, 32'h3000);
    plog.delete();
    pend = 1'b0;
    auto_run(6, 1'b1);
    chk("rr_first_pc",
        plog.size() > 0 ? plog[0] : 32'hffff_ffff, 32'h3000);

    // reset mid-WAIT, late rvalid ignored
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("rw_req", 32'(bus.imem_req), 32'd1);
    chk("rw_addr", bus.imem_addr, 32'h100);
    chk("rw_valid", 32'(bus.id_valid), 32'd0);
    chk("rw_inst", bus.id_inst, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("rw_cnt", 32'(bus.fifo_count), 32'd0);
    chk("rw_addr2", bus.imem_addr, 32'h100);

    // pc wrap at top of address space
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hffff_fffe);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap_a0", bus.imem_addr, 32'hffff_fffc);
    chk("wrap_req", 32'(bus.imem_req), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_a1", bus.imem_addr, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap_req2", 32'(bus.imem_req), 32'd1);
    chk("wrap_addr", bus.imem_addr, 32'h0);
    chk("wrap_pc", bus.id_pc, 32'hffff_fffc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
